// File: rtl/glitch_pkg.sv
// Shared types and default build constants for the glitch sequencer.
package glitch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_PULSE = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } glitch_state_e;

  localparam int   DEF_DELAY_W       = 32;
  localparam int   DEF_WIDTH_W       = 16;
  localparam int   DEF_COUNT_W       = 4;
  localparam logic DEF_GLITCH_ACTIVE = 1'b1;

endpackage

// File: rtl/glitch_sequencer_if.sv
// Control, configuration and status bundle of the glitch sequencer.
interface glitch_sequencer_if #(
  parameter int DELAY_W = glitch_pkg::DEF_DELAY_W,
  parameter int WIDTH_W = glitch_pkg::DEF_WIDTH_W,
  parameter int COUNT_W = glitch_pkg::DEF_COUNT_W
);
  // arm is a one-cycle strobe honoured only in IDLE without abort; abort is
  // a level sampled every cycle and wins over everything; no ready/ack path.
  logic                        arm;
  logic                        abort;
  logic                        trigger;
  logic                        trig_falling;
  logic [DELAY_W-1:0]          delay_cfg;
  logic [WIDTH_W-1:0]          width_cfg;
  logic [WIDTH_W-1:0]          gap_cfg;
  logic [COUNT_W-1:0]          count_cfg;
  logic                        glitch;
  logic                        armed;
  logic                        delay_active;
  logic                        done;
  logic [COUNT_W-1:0]          pulse_idx;
  glitch_pkg::glitch_state_e   state;

  modport master (
    output arm, abort, trigger, trig_falling, delay_cfg, width_cfg, gap_cfg, count_cfg,
    input  glitch, armed, delay_active, done, pulse_idx, state
  );

  modport slave (
    input  arm, abort, trigger, trig_falling, delay_cfg, width_cfg, gap_cfg, count_cfg,
    output glitch, armed, delay_active, done, pulse_idx, state
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous levels into the clk domain.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/glitch_sequencer.sv
// Trigger-aligned glitch pulse train generator: arm, wait for an edge, delay,
// then emit count pulses of fixed width separated by fixed gaps.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int   DELAY_W       = DEF_DELAY_W,
  parameter int   WIDTH_W       = DEF_WIDTH_W,
  parameter int   COUNT_W       = DEF_COUNT_W,
  parameter logic GLITCH_ACTIVE = DEF_GLITCH_ACTIVE
) (
  input  logic               clk,
  input  logic               rst_n,
  glitch_sequencer_if.slave  bus
);
  glitch_state_e        r_state, w_next_state;
  logic [DELAY_W-1:0]   r_delay, r_delay_cnt, w_delay_cnt_nxt;
  logic [WIDTH_W-1:0]   r_width, r_gap, r_phase_cnt, w_phase_cnt_nxt;
  logic [COUNT_W-1:0]   r_count, r_pulse_idx, w_pulse_idx_nxt;
  logic                 r_falling;
  logic                 r_glitch, r_armed, r_delay_active, r_done, w_done_nxt;
  logic                 w_trig_s, r_trig_d;
  logic                 w_edge, w_trig_idle, w_arm_ok;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.trigger),
    .o_q   (w_trig_s)
  );

  assign w_edge      = r_falling ? (r_trig_d & ~w_trig_s) : (w_trig_s & ~r_trig_d);
  assign w_trig_idle = r_falling ? w_trig_s : ~w_trig_s;
  assign w_arm_ok    = (r_state == S_IDLE) && bus.arm && !bus.abort;

  always_comb begin
    w_next_state    = r_state;
    w_delay_cnt_nxt = r_delay_cnt;
    w_phase_cnt_nxt = r_phase_cnt;
    w_pulse_idx_nxt = r_pulse_idx;
    w_done_nxt      = r_done;
    if (bus.abort) begin
      w_next_state    = S_IDLE;
      w_delay_cnt_nxt = '0;
      w_phase_cnt_nxt = '0;
      w_pulse_idx_nxt = '0;
      w_done_nxt      = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.arm) begin
            w_next_state    = S_ARMED;
            w_delay_cnt_nxt = '0;
            w_phase_cnt_nxt = '0;
            w_pulse_idx_nxt = '0;
            w_done_nxt      = 1'b0;
          end
        end
        S_ARMED: begin
          // A zero delay skips DELAY so the first pulse lands one cycle after the edge.
          if (w_edge) begin
            w_next_state    = (r_delay == '0) ? S_PULSE : S_DELAY;
            w_delay_cnt_nxt = '0;
            w_phase_cnt_nxt = '0;
            w_pulse_idx_nxt = '0;
          end
        end
        S_DELAY: begin
          if (r_delay_cnt == r_delay - DELAY_W'(1)) begin
            w_next_state    = S_PULSE;
            w_delay_cnt_nxt = '0;
            w_phase_cnt_nxt = '0;
          end else begin
            w_delay_cnt_nxt = r_delay_cnt + DELAY_W'(1);
          end
        end
        S_PULSE: begin
          if (r_phase_cnt == r_width - WIDTH_W'(1)) begin
            w_phase_cnt_nxt = '0;
            if (r_pulse_idx == r_count - COUNT_W'(1)) begin
              w_next_state = S_DONE;
              w_done_nxt   = 1'b1;
            end else begin
              w_next_state = S_GAP;
            end
          end else begin
            w_phase_cnt_nxt = r_phase_cnt + WIDTH_W'(1);
          end
        end
        S_GAP: begin
          if (r_phase_cnt == r_gap - WIDTH_W'(1)) begin
            w_next_state    = S_PULSE;
            w_phase_cnt_nxt = '0;
            w_pulse_idx_nxt = r_pulse_idx + COUNT_W'(1);
          end else begin
            w_phase_cnt_nxt = r_phase_cnt + WIDTH_W'(1);
          end
        end
        S_DONE: begin
          if (w_trig_idle) w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_delay_cnt    <= '0;
      r_phase_cnt    <= '0;
      r_pulse_idx    <= '0;
      r_done         <= 1'b0;
      r_armed        <= 1'b0;
      r_delay_active <= 1'b0;
      r_glitch       <= ~GLITCH_ACTIVE;
      r_trig_d       <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_delay_cnt    <= w_delay_cnt_nxt;
      r_phase_cnt    <= w_phase_cnt_nxt;
      r_pulse_idx    <= w_pulse_idx_nxt;
      r_done         <= w_done_nxt;
      r_armed        <= (w_next_state == S_ARMED);
      r_delay_active <= (w_next_state == S_DELAY);
      r_glitch       <= (w_next_state == S_PULSE) ? GLITCH_ACTIVE : ~GLITCH_ACTIVE;
      r_trig_d       <= w_trig_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delay   <= '0;
      r_width   <= '0;
      r_gap     <= '0;
      r_count   <= '0;
      r_falling <= 1'b0;
    end else if (w_arm_ok) begin
      r_delay   <= bus.delay_cfg;
      r_width   <= (bus.width_cfg == '0) ? WIDTH_W'(1) : bus.width_cfg;
      r_gap     <= (bus.gap_cfg == '0)   ? WIDTH_W'(1) : bus.gap_cfg;
      r_count   <= (bus.count_cfg == '0) ? COUNT_W'(1) : bus.count_cfg;
      r_falling <= bus.trig_falling;
    end
  end

  assign bus.glitch       = r_glitch;
  assign bus.armed        = r_armed;
  assign bus.delay_active = r_delay_active;
  assign bus.done         = r_done;
  assign bus.pulse_idx    = r_pulse_idx;
  assign bus.state        = r_state;
endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer using a small build so that the
// all-ones delay and maximum width/count cases stay short.
module tb_glitch_sequencer;
  import glitch_pkg::*;

  localparam int   DW = 6;
  localparam int   WW = 5;
  localparam int   CW = 3;
  localparam logic GA = 1'b1;
  localparam int   SW = 4 + CW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic [SW-1:0] exp_q[$];

  glitch_sequencer_if #(.DELAY_W(DW), .WIDTH_W(WW), .COUNT_W(CW)) bus ();

  glitch_sequencer #(
    .DELAY_W(DW), .WIDTH_W(WW), .COUNT_W(CW), .GLITCH_ACTIVE(GA)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  // Expected {glitch, done, delay_active, armed, pulse_idx} on the cycle after
  // posedge n, given the trigger was driven just after posedge k. Two sync
  // flops plus the edge flop put the detected edge (T) at k+2.
  function automatic logic [SW-1:0] model(input int n, input int k, input int d,
                                          input int w, input int g, input int c);
    int n0, per, i;
    logic gl, dn, da, ar;
    logic [CW-1:0] pi;
    n0  = k + 2 + d + 1;
    per = w + g;
    ar  = (n <= k + 2);
    da  = (n >= k + 3) && (n < n0);
    if (n < n0) begin
      gl = 1'b0;
      pi = '0;
    end else begin
      i  = (n - n0) / per;
      gl = (i < c) && (((n - n0) % per) < w);
      pi = CW'((i < c) ? i : c - 1);
    end
    dn = (n >= n0 + c * w + (c - 1) * g);
    return {(gl ? GA : ~GA), dn, da, ar, pi};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int d, input int w, input int g, input int c, input bit f);
    step();
    bus.delay_cfg    = DW'(d);
    bus.width_cfg    = WW'(w);
    bus.gap_cfg      = WW'(g);
    bus.count_cfg    = CW'(c);
    bus.trig_falling = f;
    bus.arm          = 1'b1;
    step();
    bus.arm          = 1'b0;
    bus.delay_cfg    = DW'($urandom);
    bus.width_cfg    = WW'($urandom);
    bus.gap_cfg      = WW'($urandom);
    bus.count_cfg    = CW'($urandom);
    bus.trig_falling = 1'($urandom);
  endtask

  task automatic run_shot(input int d, input int w, input int g, input int c,
                          input bit falling, input string name);
    int we, ge, ce, k, r, nn;
    logic [SW-1:0] exp_v, got_v;
    glitch_state_e exp_s;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    ce = (c == 0) ? 1 : c;
    bus.trigger = 1'b0;
    repeat (4) step();
    do_arm(d, w, g, c, falling);
    // Armed window: the wrong-polarity edge and a second arm must both be ignored.
    for (int j = 0; j < 6; j++) begin
      if (j == 0 && falling) bus.trigger = 1'b1;
      if (j == 1) begin
        bus.arm       = 1'b1;
        bus.delay_cfg = DW'($urandom);
        bus.width_cfg = WW'($urandom);
      end
      if (j == 2) bus.arm = 1'b0;
      @(negedge clk);
      if (bus.armed !== 1'b1 || bus.glitch !== ~GA || bus.state !== S_ARMED) begin
        errors++;
        $display("FAIL %s armed_wait: armed=%b glitch=%b state=%s, need armed=1 glitch=%b state=S_ARMED",
                 name, bus.armed, bus.glitch, bus.state.name(), ~GA);
      end
      checks++;
      step();
    end
    bus.trigger = falling ? 1'b0 : 1'b1;
    k  = cyc;
    nn = 3 + d + ce * we + (ce - 1) * ge + 4;
    for (int n = k; n < k + nn; n++) exp_q.push_back(model(n, k, d, we, ge, ce));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {bus.glitch, bus.done, bus.delay_active, bus.armed, bus.pulse_idx};
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s wave @T+%0d: {glitch,done,dly,armed,idx} got %b_%b_%b_%b_%0d need %b_%b_%b_%b_%0d",
                 name, cyc - k - 2, got_v[SW-1], got_v[SW-2], got_v[SW-3], got_v[SW-4], got_v[CW-1:0],
                 exp_v[SW-1], exp_v[SW-2], exp_v[SW-3], exp_v[SW-4], exp_v[CW-1:0]);
      end
      checks++;
    end
    step();
    bus.trigger = falling ? 1'b1 : 1'b0;
    r = cyc;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      exp_s = (cyc >= r + 3) ? S_IDLE : S_DONE;
      if (bus.state !== exp_s) begin
        errors++;
        $display("FAIL %s done_exit: state=%s need %s", name, bus.state.name(), exp_s.name());
      end
      checks++;
    end
    if (bus.done !== 1'b1 || bus.glitch !== ~GA || bus.pulse_idx !== CW'(ce - 1)) begin
      errors++;
      $display("FAIL %s idle_after_done: done=%b glitch=%b idx=%0d need done=1 glitch=%b idx=%0d",
               name, bus.done, bus.glitch, bus.pulse_idx, ~GA, ce - 1);
    end
    checks++;
  endtask

  // tests
  task automatic test_reset();
    bus.arm = 1'b0; bus.abort = 1'b0; bus.trigger = 1'b0; bus.trig_falling = 1'b0;
    bus.delay_cfg = '0; bus.width_cfg = '0; bus.gap_cfg = '0; bus.count_cfg = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    if (bus.glitch !== ~GA || bus.armed !== 1'b0 || bus.delay_active !== 1'b0 ||
        bus.done !== 1'b0 || bus.pulse_idx !== '0 || bus.state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_values: glitch=%b armed=%b dly=%b done=%b idx=%0d state=%s need %b 0 0 0 0 S_IDLE",
               bus.glitch, bus.armed, bus.delay_active, bus.done, bus.pulse_idx, bus.state.name(), ~GA);
    end
    checks++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_pulse();
    run_shot(10, 3, 5, 1, 1'b0, "single_pulse");
  endtask

  task automatic test_pulse_train();
    run_shot(0, 2, 4, 3, 1'b0, "pulse_train");
  endtask

  task automatic test_falling_mode();
    run_shot(3, 2, 1, 2, 1'b1, "falling_mode");
  endtask

  task automatic test_abort();
    int k, s1;
    bus.trigger = 1'b0;
    repeat (4) step();
    do_arm(2, 4, 3, 3, 1'b0);
    step();
    bus.trigger = 1'b1;
    k  = cyc;
    s1 = k + 5 + 7;
    while (cyc < s1 + 1) step();
    if (bus.glitch !== GA || bus.pulse_idx !== CW'(1)) begin
      errors++;
      $display("FAIL abort_pre: glitch=%b idx=%0d need glitch=%b idx=1", bus.glitch, bus.pulse_idx, GA);
    end
    checks++;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    if (bus.glitch !== ~GA || bus.state !== S_IDLE || bus.done !== 1'b0 || bus.pulse_idx !== '0) begin
      errors++;
      $display("FAIL abort_post: glitch=%b state=%s done=%b idx=%0d need %b S_IDLE 0 0",
               bus.glitch, bus.state.name(), bus.done, bus.pulse_idx, ~GA);
    end
    checks++;
    bus.trigger = 1'b0;
    repeat (4) step();
    bus.trigger = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.glitch !== ~GA || bus.state !== S_IDLE) begin
        errors++;
        $display("FAIL abort_trigger_ignored: glitch=%b state=%s need %b S_IDLE",
                 bus.glitch, bus.state.name(), ~GA);
      end
      checks++;
    end
    step();
  endtask

  task automatic test_reset_mid_pulse();
    int k, n0;
    bus.trigger = 1'b0;
    repeat (4) step();
    do_arm(1, 6, 1, 2, 1'b0);
    step();
    bus.trigger = 1'b1;
    k  = cyc;
    n0 = k + 4;
    while (cyc < n0 + 2) step();
    #2;
    if (bus.glitch !== GA) begin
      errors++;
      $display("FAIL reset_mid_pre: glitch=%b need %b", bus.glitch, GA);
    end
    checks++;
    rst_n = 1'b0;
    #1;
    if (bus.glitch !== ~GA || bus.state !== S_IDLE || bus.armed !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: glitch=%b state=%s armed=%b done=%b need %b S_IDLE 0 0",
               bus.glitch, bus.state.name(), bus.armed, bus.done, ~GA);
    end
    checks++;
    step();
    rst_n = 1'b1;
    bus.trigger = 1'b0;
    repeat (4) step();
    bus.trigger = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (bus.glitch !== ~GA || bus.state !== S_IDLE || bus.armed !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_arm: glitch=%b state=%s armed=%b need %b S_IDLE 0",
                 bus.glitch, bus.state.name(), bus.armed, ~GA);
      end
      checks++;
    end
    step();
  endtask

  task automatic test_arm_with_abort();
    step();
    bus.delay_cfg = DW'(5); bus.width_cfg = WW'(2); bus.count_cfg = CW'(1);
    bus.arm = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (bus.state !== S_IDLE || bus.armed !== 1'b0) begin
        errors++;
        $display("FAIL arm_with_abort: state=%s armed=%b need S_IDLE 0", bus.state.name(), bus.armed);
      end
      checks++;
    end
  endtask

  task automatic test_max_delay();
    run_shot((1 << DW) - 1, 0, 0, 0, 1'b0, "max_delay_zero_cfg");
  endtask

  task automatic test_max_all();
    run_shot((1 << DW) - 1, (1 << WW) - 1, (1 << WW) - 1, (1 << CW) - 1, 1'b1, "max_all");
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      run_shot($urandom_range(0, 20), $urandom_range(0, 5), $urandom_range(0, 5),
               $urandom_range(0, 5), 1'($urandom_range(0, 1)), $sformatf("random_%0d", s));
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_pulse_train();
    test_falling_mode();
    test_abort();
    test_reset_mid_pulse();
    test_arm_with_abort();
    test_max_delay();
    test_max_all();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
